// File: rtl/nasti_stream_pkg.sv
// Shared types and helpers for the NASTI-Stream width down-converter.
package nasti_stream_pkg;

  // Largest supported wide/narrow ratio; slice indices are sized for it.
  localparam int unsigned MAX_MULTIPLE = 64;
  localparam int unsigned IDX_W        = 6;

  // Default configuration (128-bit master, 32-bit slave).
  localparam int unsigned DEF_MULTIPLE    = 128 / 32;
  localparam int unsigned DEF_SLICE_BYTES = 32 / 8;

  // Slice index within a wide beat.
  typedef logic [IDX_W-1:0] slice_t;

  // Pending-slice mask, zero-extended to the maximum ratio.
  typedef logic [MAX_MULTIPLE-1:0] mask_t;

  typedef struct packed {
    logic   found;
    slice_t idx;
  } lowest_t;

  // Index of the least-significant set bit of mask, with a found flag.
  function automatic lowest_t lowest_set(input mask_t mask);
    lowest_t r;
    r = '0;
    for (int unsigned i = 0; i < MAX_MULTIPLE; i++) begin
      if (mask[i] && !r.found) begin
        r.found = 1'b1;
        r.idx   = slice_t'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/nasti_stream_slice_sel.sv
// Combinational slice selection: muxes the current slice out of the held
// wide beat and works out the pending mask / index after it is consumed.
module nasti_stream_slice_sel
  import nasti_stream_pkg::*;
#(
  parameter int unsigned MULTIPLE    = 4,
  parameter int unsigned SLICE_WIDTH = 32,
  localparam int unsigned SB         = SLICE_WIDTH / 8
) (
  input  logic [MULTIPLE-1:0]             i_pending,
  input  slice_t                          i_idx,
  input  logic [MULTIPLE*SLICE_WIDTH-1:0] i_data,
  input  logic [MULTIPLE*SB-1:0]          i_strb,
  input  logic [MULTIPLE*SB-1:0]          i_keep,
  output logic [MULTIPLE-1:0]             o_pending_next,
  output slice_t                          o_next_idx,
  output logic                            o_is_final,
  output logic [SLICE_WIDTH-1:0]          o_data,
  output logic [SB-1:0]                   o_strb,
  output logic [SB-1:0]                   o_keep
);

  lowest_t w_next_low;

  // Clear the current slice from the mask and mux out its data/strb/keep.
  always_comb begin
    o_pending_next = '0;
    o_data         = '0;
    o_strb         = '0;
    o_keep         = '0;
    for (int unsigned i = 0; i < MULTIPLE; i++) begin
      o_pending_next[i] = i_pending[i] && (i_idx != slice_t'(i));
      if (i_idx == slice_t'(i)) begin
        o_data = i_data[i*SLICE_WIDTH +: SLICE_WIDTH];
        o_strb = i_strb[i*SB +: SB];
        o_keep = i_keep[i*SB +: SB];
      end
    end
  end

  assign w_next_low = lowest_set(mask_t'(o_pending_next));
  assign o_next_idx = w_next_low.found ? w_next_low.idx : '0;
  assign o_is_final = ~|o_pending_next;

endmodule

// File: rtl/nasti_stream_packer.sv
// NASTI-Stream width down-converter: splits each wide master beat into
// narrow slave beats, LS slice first, optionally skipping null slices and
// moving t_last onto the last slice actually emitted.
module nasti_stream_packer
  import nasti_stream_pkg::*;
#(
  parameter int unsigned ID_WIDTH          = 1,
  parameter int unsigned DEST_WIDTH        = 1,
  parameter int unsigned USER_WIDTH        = 1,
  parameter int unsigned MASTER_DATA_WIDTH = 128,
  parameter int unsigned SLAVE_DATA_WIDTH  = 32,
  parameter bit          SKIP_NULL         = 1'b1
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  // wide input stream
  input  logic                           i_m_t_valid,
  output logic                           o_m_t_ready,
  input  logic [MASTER_DATA_WIDTH-1:0]   i_m_t_data,
  input  logic [MASTER_DATA_WIDTH/8-1:0] i_m_t_strb,
  input  logic [MASTER_DATA_WIDTH/8-1:0] i_m_t_keep,
  input  logic                           i_m_t_last,
  input  logic [ID_WIDTH-1:0]            i_m_t_id,
  input  logic [DEST_WIDTH-1:0]          i_m_t_dest,
  input  logic [USER_WIDTH-1:0]          i_m_t_user,
  // narrow output stream
  output logic                           o_s_t_valid,
  input  logic                           i_s_t_ready,
  output logic [SLAVE_DATA_WIDTH-1:0]    o_s_t_data,
  output logic [SLAVE_DATA_WIDTH/8-1:0]  o_s_t_strb,
  output logic [SLAVE_DATA_WIDTH/8-1:0]  o_s_t_keep,
  output logic                           o_s_t_last,
  output logic [ID_WIDTH-1:0]            o_s_t_id,
  output logic [DEST_WIDTH-1:0]          o_s_t_dest,
  output logic [USER_WIDTH-1:0]          o_s_t_user
);

  localparam int unsigned MULTIPLE    = MASTER_DATA_WIDTH / SLAVE_DATA_WIDTH;
  localparam int unsigned SLICE_BYTES = SLAVE_DATA_WIDTH / 8;
  localparam int unsigned MB          = MASTER_DATA_WIDTH / 8;

  if (MASTER_DATA_WIDTH % SLAVE_DATA_WIDTH != 0) begin : g_chk_div
    $error("SLAVE_DATA_WIDTH must divide MASTER_DATA_WIDTH");
  end
  if (MULTIPLE < 2) begin : g_chk_ratio
    $error("MASTER_DATA_WIDTH / SLAVE_DATA_WIDTH must be at least 2");
  end
  if (MULTIPLE > MAX_MULTIPLE) begin : g_chk_max
    $error("width ratio exceeds MAX_MULTIPLE");
  end

  // holding register
  logic                         r_occupied;
  logic [MULTIPLE-1:0]          r_pending;
  slice_t                       r_idx;
  logic [MASTER_DATA_WIDTH-1:0] r_data;
  logic [MB-1:0]                r_strb;
  logic [MB-1:0]                r_keep;
  logic                         r_last;
  logic [ID_WIDTH-1:0]          r_id;
  logic [DEST_WIDTH-1:0]        r_dest;
  logic [USER_WIDTH-1:0]        r_user;

  logic [MULTIPLE-1:0]          w_load_pending;
  lowest_t                      w_load_low;
  slice_t                       w_load_idx;
  logic [MULTIPLE-1:0]          w_pending_next;
  slice_t                       w_next_idx;
  logic                         w_is_final;
  logic                         w_s_hs;
  logic                         w_m_hs;
  logic                         w_m_ready;

  nasti_stream_slice_sel #(
    .MULTIPLE    (MULTIPLE),
    .SLICE_WIDTH (SLAVE_DATA_WIDTH)
  ) u_slice_sel (
    .i_pending      (r_pending),
    .i_idx          (r_idx),
    .i_data         (r_data),
    .i_strb         (r_strb),
    .i_keep         (r_keep),
    .o_pending_next (w_pending_next),
    .o_next_idx     (w_next_idx),
    .o_is_final     (w_is_final),
    .o_data         (o_s_t_data),
    .o_strb         (o_s_t_strb),
    .o_keep         (o_s_t_keep)
  );

  // Pending mask for an incoming beat; an all-null beat still emits slice 0.
  always_comb begin
    w_load_pending = '0;
    for (int unsigned i = 0; i < MULTIPLE; i++) begin
      w_load_pending[i] = SKIP_NULL ? |i_m_t_keep[i*SLICE_BYTES +: SLICE_BYTES] : 1'b1;
    end
    if (w_load_pending == '0) begin
      w_load_pending[0] = 1'b1;
    end
  end

  assign w_load_low = lowest_set(mask_t'(w_load_pending));
  assign w_load_idx = w_load_low.found ? w_load_low.idx : '0;

  // Accept a new beat in the same cycle the final slice leaves.
  assign w_s_hs    = r_occupied && i_s_t_ready;
  assign w_m_ready = !r_occupied || (w_s_hs && w_is_final);
  assign w_m_hs    = i_m_t_valid && w_m_ready;

  // Occupancy, pending mask and slice index.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_occupied <= 1'b0;
      r_pending  <= '0;
      r_idx      <= '0;
    end else if (w_m_hs) begin
      r_occupied <= 1'b1;
      r_pending  <= w_load_pending;
      r_idx      <= w_load_idx;
    end else if (w_s_hs) begin
      r_pending  <= w_pending_next;
      r_idx      <= w_next_idx;
      if (w_is_final) begin
        r_occupied <= 1'b0;
      end
    end
  end

  // Wide-beat payload capture; contents are don't-care while empty.
  always_ff @(posedge aclk) begin
    if (w_m_hs) begin
      r_data <= i_m_t_data;
      r_strb <= i_m_t_strb;
      r_keep <= i_m_t_keep;
      r_last <= i_m_t_last;
      r_id   <= i_m_t_id;
      r_dest <= i_m_t_dest;
      r_user <= i_m_t_user;
    end
  end

  assign o_m_t_ready = w_m_ready;
  assign o_s_t_valid = r_occupied;
  // r_last is unreset, so gate it with occupancy to keep t_last low after reset.
  assign o_s_t_last  = r_occupied && r_last && w_is_final;
  assign o_s_t_id    = r_id;
  assign o_s_t_dest  = r_dest;
  assign o_s_t_user  = r_user;

endmodule

// File: tb/tb_nasti_stream_packer.sv
// Directed bench for nasti_stream_packer (128 -> 32, SKIP_NULL on and off).
module tb_nasti_stream_packer;

  logic         aclk;
  logic         aresetn;
  logic         m_valid, m_valid0;
  logic [127:0] m_data;
  logic [15:0]  m_strb, m_keep;
  logic         m_last;
  logic [0:0]   m_id, m_dest, m_user;
  logic         s_ready;

  logic         m_ready, s_valid, s_last;
  logic [31:0]  s_data;
  logic [3:0]   s_strb, s_keep;
  logic [0:0]   s_id, s_dest, s_user;

  logic         m_ready0, s_valid0, s_last0;
  logic [31:0]  s_data0;
  logic [3:0]   s_strb0, s_keep0;
  logic [0:0]   s_id0, s_dest0, s_user0;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] D1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] D2 = 128'h88888888_77777777_66666666_55555555;
  localparam logic [127:0] DA = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
  localparam logic [127:0] DB = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;

  nasti_stream_packer #(
    .MASTER_DATA_WIDTH (128),
    .SLAVE_DATA_WIDTH  (32),
    .SKIP_NULL         (1'b1)
  ) u_dut (
    .aclk (aclk), .aresetn (aresetn),
    .i_m_t_valid (m_valid), .o_m_t_ready (m_ready), .i_m_t_data (m_data),
    .i_m_t_strb (m_strb), .i_m_t_keep (m_keep), .i_m_t_last (m_last),
    .i_m_t_id (m_id), .i_m_t_dest (m_dest), .i_m_t_user (m_user),
    .o_s_t_valid (s_valid), .i_s_t_ready (s_ready), .o_s_t_data (s_data),
    .o_s_t_strb (s_strb), .o_s_t_keep (s_keep), .o_s_t_last (s_last),
    .o_s_t_id (s_id), .o_s_t_dest (s_dest), .o_s_t_user (s_user)
  );

  nasti_stream_packer #(
    .MASTER_DATA_WIDTH (128),
    .SLAVE_DATA_WIDTH  (32),
    .SKIP_NULL         (1'b0)
  ) u_dut0 (
    .aclk (aclk), .aresetn (aresetn),
    .i_m_t_valid (m_valid0), .o_m_t_ready (m_ready0), .i_m_t_data (m_data),
    .i_m_t_strb (m_strb), .i_m_t_keep (m_keep), .i_m_t_last (m_last),
    .i_m_t_id (m_id), .i_m_t_dest (m_dest), .i_m_t_user (m_user),
    .o_s_t_valid (s_valid0), .i_s_t_ready (s_ready), .o_s_t_data (s_data0),
    .o_s_t_strb (s_strb0), .o_s_t_keep (s_keep0), .o_s_t_last (s_last0),
    .o_s_t_id (s_id0), .o_s_t_dest (s_dest0), .o_s_t_user (s_user0)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [31:0] d, input logic [3:0] k,
                      input logic l, input logic mr);
    chk({tag, ".valid"}, 128'(s_valid), 128'(1'b1));
    chk({tag, ".data"},  128'(s_data),  128'(d));
    chk({tag, ".keep"},  128'(s_keep),  128'(k));
    chk({tag, ".last"},  128'(s_last),  128'(l));
    chk({tag, ".mrdy"},  128'(m_ready), 128'(mr));
  endtask

  task automatic beat0(input string tag, input logic [31:0] d, input logic [3:0] k,
                       input logic l, input logic mr);
    chk({tag, ".valid"}, 128'(s_valid0), 128'(1'b1));
    chk({tag, ".data"},  128'(s_data0),  128'(d));
    chk({tag, ".keep"},  128'(s_keep0),  128'(k));
    chk({tag, ".last"},  128'(s_last0),  128'(l));
    chk({tag, ".mrdy"},  128'(m_ready0), 128'(mr));
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } exp_t;

  initial begin
    exp_t         q[$];
    exp_t         e;
    logic [127:0] b_data[4];
    logic [15:0]  b_keep[4];
    logic         b_last[4];
    int           bi;
    int           cyc;
    int           popped;
    logic         stalled;
    logic         m_hs;
    logic [31:0]  p_data;
    logic [3:0]   p_keep;
    logic         p_last;

    aresetn = 1'b1;
    m_valid = 1'b0; m_valid0 = 1'b0;
    m_data = '0; m_strb = '0; m_keep = '0; m_last = 1'b0;
    m_id = '0; m_dest = '0; m_user = '0;
    s_ready = 1'b0;

    // reset state
    #2 aresetn = 1'b0;
    #1;
    chk("rst.valid", 128'(s_valid), 128'(1'b0));
    chk("rst.last",  128'(s_last),  128'(1'b0));
    chk("rst.mrdy",  128'(m_ready), 128'(1'b1));
    chk("rst.valid0", 128'(s_valid0), 128'(1'b0));
    tick(); tick();
    aresetn = 1'b1;
    tick();

    // 1: full beat, four slices, t_last on the fourth
    m_valid = 1'b1; m_data = D1; m_keep = 16'hFFFF; m_strb = 16'h5A5A; m_last = 1'b1;
    s_ready = 1'b1;
    tick();
    m_valid = 1'b0;
    #1;
    beat("t1.s0", 32'h11111111, 4'hF, 1'b0, 1'b0);
    chk("t1.strb0", 128'(s_strb), 128'(4'hA));
    tick(); #1; beat("t1.s1", 32'h22222222, 4'hF, 1'b0, 1'b0);
    tick(); #1; beat("t1.s2", 32'h33333333, 4'hF, 1'b0, 1'b0);
    tick(); #1; beat("t1.s3", 32'h44444444, 4'hF, 1'b1, 1'b1);
    chk("t1.strb3", 128'(s_strb), 128'(4'h5));
    tick(); #1;
    chk("t1.empty", 128'(s_valid), 128'(1'b0));
    chk("t1.mrdy_empty", 128'(m_ready), 128'(1'b1));

    // 2: back-to-back beats, no gap between A3 and B0
    m_valid = 1'b1; m_data = DA; m_keep = 16'hFFFF; m_strb = 16'hFFFF; m_last = 1'b0;
    tick();
    m_data = DB; m_last = 1'b1;
    #1;
    beat("t2.a0", 32'hA0A0A0A0, 4'hF, 1'b0, 1'b0);
    tick(); #1; beat("t2.a1", 32'hA1A1A1A1, 4'hF, 1'b0, 1'b0);
    tick(); #1; beat("t2.a2", 32'hA2A2A2A2, 4'hF, 1'b0, 1'b0);
    tick(); #1; beat("t2.a3", 32'hA3A3A3A3, 4'hF, 1'b0, 1'b1);
    tick();
    m_valid = 1'b0;
    #1;
    beat("t2.b0", 32'hB0B0B0B0, 4'hF, 1'b0, 1'b0);
    tick(); #1; beat("t2.b1", 32'hB1B1B1B1, 4'hF, 1'b0, 1'b0);
    tick(); #1; beat("t2.b2", 32'hB2B2B2B2, 4'hF, 1'b0, 1'b0);
    tick(); #1; beat("t2.b3", 32'hB3B3B3B3, 4'hF, 1'b1, 1'b1);
    tick(); #1;
    chk("t2.empty", 128'(s_valid), 128'(1'b0));

    // 3: sparse keep, null slices skipped
    m_valid = 1'b1; m_data = D1; m_keep = 16'h0F0F; m_last = 1'b1;
    tick();
    m_valid = 1'b0;
    #1;
    beat("t3.s0", 32'h11111111, 4'hF, 1'b0, 1'b0);
    tick(); #1; beat("t3.s2", 32'h33333333, 4'hF, 1'b1, 1'b1);
    tick(); #1;
    chk("t3.empty", 128'(s_valid), 128'(1'b0));

    // 3b: same beat with SKIP_NULL=0 emits every slice
    m_valid0 = 1'b1;
    tick();
    m_valid0 = 1'b0;
    #1;
    beat0("t3b.s0", 32'h11111111, 4'hF, 1'b0, 1'b0);
    tick(); #1; beat0("t3b.s1", 32'h22222222, 4'h0, 1'b0, 1'b0);
    tick(); #1; beat0("t3b.s2", 32'h33333333, 4'hF, 1'b0, 1'b0);
    tick(); #1; beat0("t3b.s3", 32'h44444444, 4'h0, 1'b1, 1'b1);
    tick(); #1;
    chk("t3b.empty", 128'(s_valid0), 128'(1'b0));
    chk("t3b.main_idle", 128'(s_valid), 128'(1'b0));

    // 4: all-null beat still emits one beat carrying last and id
    m_valid = 1'b1; m_data = D1; m_keep = 16'h0000; m_last = 1'b1; m_id = 1'b1;
    tick();
    m_valid = 1'b0; m_id = 1'b0;
    #1;
    beat("t4.s0", 32'h11111111, 4'h0, 1'b1, 1'b1);
    chk("t4.id", 128'(s_id), 128'(1'b1));
    tick(); #1;
    chk("t4.empty", 128'(s_valid), 128'(1'b0));

    // 5: random slave backpressure against a packed reference model
    b_data[0] = D1; b_keep[0] = 16'hFFFF; b_last[0] = 1'b0;
    b_data[1] = D2; b_keep[1] = 16'hF0F0; b_last[1] = 1'b1;
    b_data[2] = DA; b_keep[2] = 16'h0000; b_last[2] = 1'b1;
    b_data[3] = DB; b_keep[3] = 16'h00F0; b_last[3] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      int n;
      n = 0;
      for (int s = 0; s < 4; s++) begin
        if (b_keep[b][4*s +: 4] != 4'h0) begin
          e.d = b_data[b][32*s +: 32]; e.k = b_keep[b][4*s +: 4]; e.l = 1'b0;
          q.push_back(e);
          n++;
        end
      end
      if (n == 0) begin
        e.d = b_data[b][31:0]; e.k = 4'h0; e.l = 1'b0;
        q.push_back(e);
      end
      q[q.size()-1].l = b_last[b];
    end

    bi = 0; cyc = 0; popped = 0; stalled = 1'b0;
    p_data = '0; p_keep = '0; p_last = 1'b0;
    m_valid = 1'b1; m_data = b_data[0]; m_keep = b_keep[0]; m_last = b_last[0];
    s_ready = ($urandom_range(0, 99) < 30);
    while ((bi < 4 || q.size() > 0) && cyc < 400) begin
      cyc++;
      @(negedge aclk);
      if (stalled) begin
        chk("t5.stable_valid", 128'(s_valid), 128'(1'b1));
        chk("t5.stable_data",  128'(s_data),  128'(p_data));
        chk("t5.stable_keep",  128'(s_keep),  128'(p_keep));
        chk("t5.stable_last",  128'(s_last),  128'(p_last));
      end
      stalled = s_valid && !s_ready;
      p_data = s_data; p_keep = s_keep; p_last = s_last;
      if (s_valid && s_ready) begin
        if (q.size() == 0) begin
          chk("t5.extra_beat", 128'(s_valid), 128'(1'b0));
        end else begin
          e = q.pop_front();
          popped++;
          chk("t5.data", 128'(s_data), 128'(e.d));
          chk("t5.keep", 128'(s_keep), 128'(e.k));
          chk("t5.last", 128'(s_last), 128'(e.l));
        end
      end
      m_hs = m_valid && m_ready;
      @(posedge aclk);
      #1;
      if (m_hs) begin
        bi++;
        if (bi < 4) begin
          m_data = b_data[bi]; m_keep = b_keep[bi]; m_last = b_last[bi];
        end else begin
          m_valid = 1'b0;
        end
      end
      s_ready = ($urandom_range(0, 99) < 30);
    end
    chk("t5.beats_sent", 128'(bi), 128'(4));
    chk("t5.drained", 128'(q.size()), 128'(0));
    chk("t5.popped", 128'(popped), 128'(8));

    // 6: asynchronous reset mid-beat
    s_ready = 1'b1;
    tick();
    m_valid = 1'b1; m_data = D1; m_keep = 16'hFFFF; m_last = 1'b1;
    tick();
    m_valid = 1'b0;
    #1;
    beat("t6.s0", 32'h11111111, 4'hF, 1'b0, 1'b0);
    tick(); #1; beat("t6.s1", 32'h22222222, 4'hF, 1'b0, 1'b0);
    tick(); #1;
    chk("t6.s2_data", 128'(s_data), 128'(32'h33333333));
    aresetn = 1'b0;
    #1;
    chk("t6.rst_valid", 128'(s_valid), 128'(1'b0));
    chk("t6.rst_last",  128'(s_last),  128'(1'b0));
    chk("t6.rst_mrdy",  128'(m_ready), 128'(1'b1));
    tick(); tick();
    aresetn = 1'b1;
    #1;
    chk("t6.post_mrdy",  128'(m_ready), 128'(1'b1));
    chk("t6.post_valid", 128'(s_valid), 128'(1'b0));
    m_valid = 1'b1; m_data = D2; m_keep = 16'hFFFF; m_last = 1'b1;
    tick();
    m_valid = 1'b0;
    #1;
    beat("t6.fresh_s0", 32'h55555555, 4'hF, 1'b0, 1'b0);
    tick(); #1; beat("t6.fresh_s1", 32'h66666666, 4'hF, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
